// File: rtl/jamesbuchanan_silly.sv
// jamesbuchanan_silly: toy 8-bit accumulator ALU tile with a free-running
// counter and an 8-bit Fibonacci LFSR.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst_n    - synchronous reset, ACTIVE-HIGH (1 = reset on next rising edge)
//   ena      - block enable; 0 freezes every state register
//   ui_in    - [2:0] opcode, [5:4] output view select, [7] step strobe,
//              [3] and [6] unused
//   uio_in   - operand B
//   uo_out   - combinational view of registered state selected by ui_in[5:4]
//   uio_out  - tied to 0x00
//   uio_oe   - tied to 0x00 (all uio pins are inputs)
module jamesbuchanan_silly (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned W = 8;
  localparam logic [W-1:0] LFSR_SEED = W'(8'h01);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_LOAD = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SEL_ACC   = 2'd0,
    SEL_CNT   = 2'd1,
    SEL_LFSR  = 2'd2,
    SEL_FLAGS = 2'd3
  } sel_e;

  logic [W-1:0] acc_q,   acc_d;
  logic         cflag_q, cflag_d;
  logic [W-1:0] cnt_q,   cnt_d;
  logic [W-1:0] lfsr_q,  lfsr_d;

  op_e          op;
  sel_e         sel;
  logic         step;
  logic [W-1:0] opb;
  logic [W:0]   sum_c;
  logic [W:0]   diff_c;
  logic         lfsr_fb_c;
  logic         flag_z_c;
  logic         flag_n_c;
  logic         unused_inputs;

  assign op   = op_e'(ui_in[2:0]);
  assign sel  = sel_e'(ui_in[5:4]);
  assign step = ui_in[7];
  assign opb  = uio_in;

  // Spare input pins are intentionally ignored.
  assign unused_inputs = ^{ui_in[6], ui_in[3]};

  // 9-bit add/sub: bit 8 of the sum is the carry, bit 8 of the difference
  // is set exactly when B > acc (borrow).
  assign sum_c  = {1'b0, acc_q} + {1'b0, opb};
  assign diff_c = {1'b0, acc_q} - {1'b0, opb};

  // Taps 8,6,5,4: maximal-length sequence, never reaches zero from the seed.
  assign lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  assign flag_z_c = (acc_q == '0);
  assign flag_n_c = acc_q[W-1];

  // Next-state logic for counter, LFSR and accumulator.
  always_comb begin
    acc_d   = acc_q;
    cflag_d = cflag_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    if (ena) begin
      cnt_d  = cnt_q + W'(1);
      lfsr_d = {lfsr_q[W-2:0], lfsr_fb_c};
      if (step) begin
        unique case (op)
          OP_NOP: begin
            acc_d = acc_q;
          end
          OP_ADD: begin
            acc_d   = sum_c[W-1:0];
            cflag_d = sum_c[W];
          end
          OP_SUB: begin
            acc_d   = diff_c[W-1:0];
            cflag_d = diff_c[W];
          end
          OP_AND:  acc_d = acc_q & opb;
          OP_OR:   acc_d = acc_q | opb;
          OP_XOR:  acc_d = acc_q ^ opb;
          OP_LOAD: acc_d = opb;
          OP_CLR: begin
            acc_d   = '0;
            cflag_d = 1'b0;
          end
          default: acc_d = acc_q;
        endcase
      end
    end
  end

  // State registers; reset wins over enable and any pending op.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_q   <= '0;
      cflag_q <= 1'b0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      acc_q   <= acc_d;
      cflag_q <= cflag_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // View mux follows the select immediately, no clock involved.
  always_comb begin
    uo_out = '0;
    unique case (sel)
      SEL_ACC:   uo_out = acc_q;
      SEL_CNT:   uo_out = cnt_q;
      SEL_LFSR:  uo_out = lfsr_q;
      SEL_FLAGS: uo_out = {flag_z_c, cflag_q, flag_n_c, 5'b00000};
      default:   uo_out = '0;
    endcase
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_jamesbuchanan_silly.sv
// Scoreboard bench for jamesbuchanan_silly: a driver applies directed and
// random stimulus, a plain-integer reference model predicts each view, and a
// monitor process pops the expectations and compares against the DUT.
module tb_jamesbuchanan_silly;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  jamesbuchanan_silly dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  int    vectors    = 0;
  int    miscompares = 0;

  // Reference model state, kept as plain integers.
  int m_acc, m_c, m_cnt, m_lfsr;
  bit m_valid = 1'b0;

  function automatic int lfsr_next(input int l);
    int p;
    p = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) & 255) | p;
  endfunction

  function automatic logic [7:0] view(input logic [1:0] s);
    int v;
    case (s)
      2'd0: v = m_acc;
      2'd1: v = m_cnt;
      2'd2: v = m_lfsr;
      default: v = ((m_acc == 0) ? 128 : 0) + (m_c ? 64 : 0) + ((m_acc >= 128) ? 32 : 0);
    endcase
    return 8'(v);
  endfunction

  task automatic model_clock(input bit r, input bit e, input logic [7:0] u, input logic [7:0] b);
    int bi;
    int s;
    bi = int'(b);
    if (r) begin
      m_acc = 0; m_c = 0; m_cnt = 0; m_lfsr = 1; m_valid = 1'b1;
    end else if (e) begin
      m_cnt  = (m_cnt + 1) % 256;
      m_lfsr = lfsr_next(m_lfsr);
      if (u[7]) begin
        case (int'(u[2:0]))
          1: begin s = m_acc + bi; m_c = (s > 255) ? 1 : 0; m_acc = s % 256; end
          2: begin m_c = (bi > m_acc) ? 1 : 0; m_acc = (m_acc - bi + 256) % 256; end
          3: m_acc = m_acc & bi;
          4: m_acc = m_acc | bi;
          5: m_acc = m_acc ^ bi;
          6: m_acc = bi;
          7: begin m_acc = 0; m_c = 0; end
          default: ;
        endcase
      end
    end
  endtask

  // One clock of stimulus: check the immediate view, then the post-edge view.
  task automatic step(input bit r, input bit e, input logic [7:0] u, input logic [7:0] b);
    @(negedge clk);
    rst_n = r; ena = e; ui_in = u; uio_in = b;
    if (m_valid) sb.push_back('{name: "comb_view", exp: view(u[5:4])});
    #2;
    @(posedge clk);
    model_clock(r, e, u, b);
    sb.push_back('{name: "seq_view", exp: view(u[5:4])});
    #2;
  endtask

  // Mid-cycle select change against a hand-derived constant.
  task automatic peek(input logic [1:0] s, input logic [7:0] k, input string nm);
    ui_in = {2'b00, s, 4'b0000};
    sb.push_back('{name: nm, exp: k});
    #2;
  endtask

  // Monitor: samples the DUT shortly after each expectation is queued.
  initial begin
    item_t it;
    forever begin
      wait (sb.size() != 0);
      #1;
      it = sb.pop_front();
      vectors++;
      if (uo_out !== it.exp) begin
        miscompares++;
        $display("FAIL %s: uo_out got %h expected %h at %0t", it.name, uo_out, it.exp, $time);
      end
      vectors++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        miscompares++;
        $display("FAIL %s_uio: uio_out/uio_oe got %h/%h expected 00/00", it.name, uio_out, uio_oe);
      end
    end
  end

  logic [7:0] lfsr_exp [4];

  initial begin
    int guard;
    rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    lfsr_exp[0] = 8'h02; lfsr_exp[1] = 8'h04; lfsr_exp[2] = 8'h08; lfsr_exp[3] = 8'h11;

    // Reset and flags after reset
    step(1, 1, 8'h00, 8'h00);
    step(1, 1, 8'h00, 8'h00);
    step(0, 1, 8'h00, 8'h00);
    peek(2'd0, 8'h00, "rst_acc");
    peek(2'd3, 8'h80, "rst_flags");

    // Load / add to negative
    step(0, 1, 8'h86, 8'h7F);
    peek(2'd0, 8'h7F, "load_7f");
    step(0, 1, 8'h81, 8'h01);
    peek(2'd0, 8'h80, "add_to_80");
    peek(2'd3, 8'h20, "flags_n");

    // Carry and wrap, then clear
    step(0, 1, 8'h86, 8'hFF);
    step(0, 1, 8'h81, 8'h01);
    peek(2'd0, 8'h00, "wrap_acc");
    peek(2'd3, 8'hC0, "flags_zc");
    step(0, 1, 8'h87, 8'h00);
    peek(2'd3, 8'h80, "clr_flags");

    // Borrow
    step(0, 1, 8'h82, 8'h01);
    peek(2'd0, 8'hFF, "borrow_acc");
    peek(2'd3, 8'h60, "borrow_flags");
    step(0, 1, 8'h82, 8'h0F);
    peek(2'd0, 8'hF0, "sub_acc");
    peek(2'd3, 8'h20, "sub_flags");

    // LFSR sequence and counter from reset
    step(1, 1, 8'h20, 8'h00);
    peek(2'd2, 8'h01, "lfsr_seed");
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h20, 8'h00);
      peek(2'd2, lfsr_exp[i], "lfsr_seq");
    end
    peek(2'd1, 8'h04, "cnt_since_rst");

    // Hold with ena low, then strobe low with ena high
    step(0, 1, 8'h86, 8'h55);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h81, 8'h01);
    peek(2'd0, 8'h55, "hold_acc");
    peek(2'd1, 8'h05, "hold_cnt");
    peek(2'd2, 8'h23, "hold_lfsr");
    step(0, 1, 8'h01, 8'h01);
    peek(2'd0, 8'h55, "nostrobe_acc");
    peek(2'd1, 8'h06, "nostrobe_cnt");

    // Randomized traffic, including unused pins and occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom));
    end

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
